// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: debounce states and frame classes.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_class_e;

    // Key code width: clog2 of the key count, never below one bit.
    function automatic int code_width(input int num_keys);
        return (num_keys <= 2) ? 1 : $clog2(num_keys);
    endfunction

endpackage

// File: rtl/keypad_frame_classify.sv
// Combinational classification of a full-frame key snapshot into
// NONE / SINGLE(code) / MULTI.
module keypad_frame_classify
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS = 12,
    parameter int CODE_W   = 4
) (
    input  logic [NUM_KEYS-1:0] snap,
    output frame_class_e        frame_class,
    output logic [CODE_W-1:0]   code
);

    logic found;
    logic multi;

    always_comb begin
        found = 1'b0;
        multi = 1'b0;
        code  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (snap[i]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    found = 1'b1;
                    code  = CODE_W'(i);
                end
            end
        end
        if (multi) begin
            frame_class = FR_MULTI;
        end else if (found) begin
            frame_class = FR_SINGLE;
        end else begin
            frame_class = FR_NONE;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: column strobe, row synchroniser, per-frame debounce
// FSM and a single-entry event register with valid/ready handshake.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 3,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int EMIT_RELEASE    = 1,
    localparam int NUM_KEYS       = NUM_ROWS * NUM_COLS,
    localparam int CODE_W         = code_width(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [NUM_COLS-1:0] col_drv,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CODE_W-1:0]   evt_code,
    output logic                evt_release,
    output logic                key_down,
    output logic                overrun,
    output logic                multi_err
);

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DF_CNT    = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Scan and synchroniser registers
    logic [NUM_ROWS-1:0] row_s1_q, row_s1_d;
    logic [NUM_ROWS-1:0] row_s2_q, row_s2_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [COL_W-1:0]    col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_drv_q, col_drv_d;
    logic [NUM_KEYS-1:0] frame_q, frame_d;

    // Debounce FSM registers
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;

    // Event output registers
    logic                evt_valid_q, evt_valid_d;
    logic [CODE_W-1:0]   evt_code_q, evt_code_d;
    logic                evt_release_q, evt_release_d;
    logic                overrun_q, overrun_d;
    logic                multi_err_q, multi_err_d;

    logic                sample;
    logic                frame_end;
    logic [NUM_KEYS-1:0] snap_now;
    frame_class_e        fr_class;
    logic [CODE_W-1:0]   fr_code;
    logic                ev_fire;
    logic                ev_rel;

    assign sample    = (div_cnt_q == LAST_DIV);
    assign frame_end = sample && (col_idx_q == LAST_COL);

    // Column strobe, dwell counter and snapshot capture. col_drv is the
    // registered one-cold image of the next column index so the strobe and
    // the index always move together.
    always_comb begin
        row_s1_d  = row_in;
        row_s2_d  = row_s1_q;
        div_cnt_d = div_cnt_q + 1'b1;
        col_idx_d = col_idx_q;
        if (sample) begin
            div_cnt_d = '0;
            col_idx_d = (col_idx_q == LAST_COL) ? '0 : col_idx_q + 1'b1;
        end
        col_drv_d            = '1;
        col_drv_d[col_idx_d] = 1'b0;

        snap_now = frame_q;
        if (sample) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                snap_now[r * NUM_COLS + int'(col_idx_q)] = ~row_s2_q[r];
            end
        end
        frame_d = snap_now;
    end

    keypad_frame_classify #(
        .NUM_KEYS (NUM_KEYS),
        .CODE_W   (CODE_W)
    ) u_classify (
        .snap        (snap_now),
        .frame_class (fr_class),
        .code        (fr_code)
    );

    // Debounce FSM, advanced only on frame end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ev_fire = 1'b0;
        ev_rel  = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fr_class == FR_SINGLE) begin
                        code_d = fr_code;
                        cnt_d  = CNT_ONE;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = ST_HELD;
                            cnt_d   = '0;
                            ev_fire = 1'b1;
                        end else begin
                            state_d = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    // A different single key restarts the debounce from idle.
                    if (fr_class == FR_SINGLE && fr_code == code_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == DF_CNT) begin
                            state_d = ST_HELD;
                            cnt_d   = '0;
                            ev_fire = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    if (fr_class == FR_NONE) begin
                        cnt_d = CNT_ONE;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            ev_fire = (EMIT_RELEASE != 0);
                            ev_rel  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (fr_class == FR_NONE) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == DF_CNT) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            ev_fire = (EMIT_RELEASE != 0);
                            ev_rel  = 1'b1;
                        end
                    end else begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    // Event register: valid/ready handshake. Contents hold while valid is
    // high and ready is low; a transfer happens on a cycle where both are
    // high. A new event overwrites only an empty or just-accepted register,
    // otherwise it is dropped and flagged on overrun.
    always_comb begin
        evt_valid_d   = evt_valid_q;
        evt_code_d    = evt_code_q;
        evt_release_d = evt_release_q;
        overrun_d     = 1'b0;
        multi_err_d   = frame_end && (fr_class == FR_MULTI);
        if (ev_fire) begin
            if (evt_valid_q && !evt_ready) begin
                overrun_d = 1'b1;
            end else begin
                evt_valid_d   = 1'b1;
                evt_code_d    = code_d;
                evt_release_d = ev_rel;
            end
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_s1_q      <= '0;
            row_s2_q      <= '0;
            div_cnt_q     <= '0;
            col_idx_q     <= '0;
            col_drv_q     <= '1;
            frame_q       <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            code_q        <= '0;
            evt_valid_q   <= 1'b0;
            evt_code_q    <= '0;
            evt_release_q <= 1'b0;
            overrun_q     <= 1'b0;
            multi_err_q   <= 1'b0;
        end else begin
            row_s1_q      <= row_s1_d;
            row_s2_q      <= row_s2_d;
            div_cnt_q     <= div_cnt_d;
            col_idx_q     <= col_idx_d;
            col_drv_q     <= col_drv_d;
            frame_q       <= frame_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            code_q        <= code_d;
            evt_valid_q   <= evt_valid_d;
            evt_code_q    <= evt_code_d;
            evt_release_q <= evt_release_d;
            overrun_q     <= overrun_d;
            multi_err_q   <= multi_err_d;
        end
    end

    assign col_drv     = col_drv_q;
    assign evt_valid   = evt_valid_q;
    assign evt_code    = evt_code_q;
    assign evt_release = evt_release_q;
    assign overrun     = overrun_q;
    assign multi_err   = multi_err_q;
    assign key_down    = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: 4x3 matrix, 4-cycle dwell, 3-frame debounce,
// one instance reporting releases (a) and one suppressing them (b).
module tb_keypad_scan;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // key matrix model: keys[r*3+c] = 1 means that key is held down
  logic [11:0] keys;

  logic [2:0] col_drv_a, col_drv_b;
  logic [3:0] row_a, row_b;
  logic       evt_valid_a, evt_ready_a, evt_release_a, key_down_a, overrun_a, multi_err_a;
  logic       evt_valid_b, evt_ready_b, evt_release_b, key_down_b, overrun_b, multi_err_b;
  logic [3:0] evt_code_a, evt_code_b;

  keypad_scan #(
    .NUM_ROWS(4), .NUM_COLS(3), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .EMIT_RELEASE(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .col_drv(col_drv_a), .row_in(row_a),
    .evt_valid(evt_valid_a), .evt_ready(evt_ready_a), .evt_code(evt_code_a),
    .evt_release(evt_release_a), .key_down(key_down_a), .overrun(overrun_a),
    .multi_err(multi_err_a)
  );

  keypad_scan #(
    .NUM_ROWS(4), .NUM_COLS(3), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .EMIT_RELEASE(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .col_drv(col_drv_b), .row_in(row_b),
    .evt_valid(evt_valid_b), .evt_ready(evt_ready_b), .evt_code(evt_code_b),
    .evt_release(evt_release_b), .key_down(key_down_b), .overrun(overrun_b),
    .multi_err(multi_err_b)
  );

  always_comb begin
    row_a = 4'hf;
    row_b = 4'hf;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (keys[r*3+c] && !col_drv_a[c]) row_a[r] = 1'b0;
        if (keys[r*3+c] && !col_drv_b[c]) row_b[r] = 1'b0;
      end
    end
  end

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  int hs_a  = 0;
  int hs_b  = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_b_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && evt_valid_a && evt_ready_a) begin
      hs_a++;
      check_eq("evt_a_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("evt_a", {evt_release_a, evt_code_a}, exp_q.pop_front());
    end
    if (rst_n && evt_valid_b && evt_ready_b) begin
      hs_b++;
      check_eq("evt_b_pending", 32'(exp_b_q.size() > 0), 32'd1);
      if (exp_b_q.size() > 0) check_eq("evt_b", {evt_release_b, evt_code_b}, exp_b_q.pop_front());
    end
  end

  // driver tasks
  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_col_drv"}, col_drv_a, 3'b111);
    check_eq({tag, "_valid"}, evt_valid_a, 1'b0);
    check_eq({tag, "_code"}, evt_code_a, 4'd0);
    check_eq({tag, "_release"}, evt_release_a, 1'b0);
    check_eq({tag, "_key_down"}, key_down_a, 1'b0);
    check_eq({tag, "_overrun"}, overrun_a, 1'b0);
    check_eq({tag, "_multi_err"}, multi_err_a, 1'b0);
    check_eq({tag, "_col_drv_b"}, col_drv_b, 3'b111);
  endtask

  // Leaves time at #1 after the first frame-end edge (frame of idle keys).
  task automatic do_reset();
    rst_n = 1'b0;
    keys  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("first_col", col_drv_a, 3'b110);
    repeat (11) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin(input logic [11:0] k);
    keys = k;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_finish();
    repeat (11) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [11:0] k);
    frame_begin(k);
    frame_finish();
  endtask

  task automatic check_event(input string tag, input logic rel, input logic [3:0] code);
    check_eq({tag, "_valid"}, evt_valid_a, 1'b1);
    check_eq({tag, "_code"}, evt_code_a, code);
    check_eq({tag, "_release"}, evt_release_a, rel);
  endtask

  bit bounce_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst_n       = 1'b0;
    keys        = '0;
    evt_ready_a = 1'b1;
    evt_ready_b = 1'b1;
    do_reset();

    // press key 5 (row 1, col 2) for three frames
    exp_q.push_back({1'b0, 4'd5});
    exp_b_q.push_back({1'b0, 4'd5});
    for (int f = 0; f < 3; f++) begin
      run_frame(12'h020);
      if (f < 2) check_eq("press5_early", evt_valid_a, 1'b0);
    end
    check_event("press5", 1'b0, 4'd5);
    check_eq("press5_key_down", key_down_a, 1'b1);
    frame_begin(12'h000);
    check_eq("press5_one_cycle", evt_valid_a, 1'b0);
    frame_finish();
    check_eq("release5_still_down", key_down_a, 1'b1);

    // release key 5
    exp_q.push_back({1'b1, 4'd5});
    run_frame(12'h000);
    run_frame(12'h000);
    check_event("release5", 1'b1, 4'd5);
    check_eq("release5_key_down", key_down_a, 1'b0);
    check_eq("b_no_release_valid", evt_valid_b, 1'b0);
    check_eq("b_key_down_fell", key_down_b, 1'b0);

    // bounce on,off,on,on,on on key 3 (row 1, col 0)
    exp_q.push_back({1'b0, 4'd3});
    exp_b_q.push_back({1'b0, 4'd3});
    for (int i = 0; i < 5; i++) begin
      run_frame(bounce_pat[i] ? 12'h008 : 12'h000);
      if (i < 4) check_eq($sformatf("bounce_f%0d", i + 1), evt_valid_a, 1'b0);
    end
    check_event("bounce_press3", 1'b0, 4'd3);
    exp_q.push_back({1'b1, 4'd3});
    for (int i = 0; i < 3; i++) run_frame(12'h000);
    check_event("release3", 1'b1, 4'd3);

    // keys 0 and 4 together: ghosting frames
    for (int i = 0; i < 3; i++) begin
      run_frame(12'h011);
      check_eq($sformatf("multi_err_f%0d", i + 1), multi_err_a, 1'b1);
      check_eq($sformatf("multi_valid_f%0d", i + 1), evt_valid_a, 1'b0);
      check_eq($sformatf("multi_key_down_f%0d", i + 1), key_down_a, 1'b0);
    end
    frame_begin(12'h000);
    check_eq("multi_err_pulse", multi_err_a, 1'b0);
    frame_finish();

    // consumer stalled: press then release key 7 (row 2, col 1)
    evt_ready_a = 1'b0;
    exp_q.push_back({1'b0, 4'd7});
    exp_b_q.push_back({1'b0, 4'd7});
    for (int i = 0; i < 3; i++) run_frame(12'h080);
    check_event("stall_press7", 1'b0, 4'd7);
    check_eq("stall_press_overrun", overrun_a, 1'b0);
    run_frame(12'h000);
    check_event("stall_hold7", 1'b0, 4'd7);
    run_frame(12'h000);
    run_frame(12'h000);
    check_eq("stall_overrun", overrun_a, 1'b1);
    check_event("stall_unchanged", 1'b0, 4'd7);
    frame_begin(12'h000);
    check_eq("stall_overrun_pulse", overrun_a, 1'b0);
    check_eq("stall_still_valid", evt_valid_a, 1'b1);
    evt_ready_a = 1'b1;
    frame_finish();
    check_eq("drain_valid", evt_valid_a, 1'b0);
    check_eq("drain_queue", exp_q.size(), 0);

    // reset in CONFIRM with two frames of key 9 counted
    run_frame(12'h200);
    run_frame(12'h200);
    check_eq("confirm_no_evt", evt_valid_a, 1'b0);
    frame_begin(12'h200);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    keys  = '0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_frame(12'h000);
      check_eq($sformatf("post_rst_f%0d", i + 1), evt_valid_a, 1'b0);
    end

    // final report
    check_eq("handshakes_a", hs_a, 5);
    check_eq("handshakes_b", hs_b, 3);
    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("exp_b_q_empty", exp_b_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
